// File: rtl/vx_gpr_bank_arb.sv
// GPR bank read scheduler: per-bank round-robin grant, writeback bank blocking, tagged response pipeline.
// Optional stall counter port perf_stalls is present only when GPR_ARB_PERF_EN is defined.
module vx_gpr_bank_arb #(
  parameter int NUM_REQS      = 4,
  parameter int NUM_BANKS     = 4,
  parameter int REG_IDX_BITS  = 8,
  parameter int TAG_WIDTH     = 2,
  parameter int READ_LATENCY  = 1,
  parameter int PERF_CTR_BITS = 16,
  localparam int BB       = $clog2(NUM_BANKS),
  localparam int BBW      = (BB > 0) ? BB : 1,
  localparam int RQB      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int ROW_BITS = REG_IDX_BITS - BB
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             req_valid,
  input  logic [NUM_REQS*REG_IDX_BITS-1:0] req_reg,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]   req_tag,
  output logic [NUM_REQS-1:0]             req_ready,
  input  logic                            wb_valid,
  input  logic [REG_IDX_BITS-1:0]         wb_reg,
  output logic [NUM_BANKS-1:0]            bank_rd_en,
  output logic [NUM_BANKS*ROW_BITS-1:0]   bank_rd_addr,
  output logic [NUM_BANKS*RQB-1:0]        bank_rd_req,
  output logic [NUM_REQS-1:0]             rsp_valid,
  output logic [NUM_REQS*BBW-1:0]         rsp_bank,
  output logic [NUM_REQS*TAG_WIDTH-1:0]   rsp_tag
`ifdef GPR_ARB_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0]        perf_stalls
`endif
);

  logic [BBW-1:0]      req_bank [NUM_REQS];
  logic [ROW_BITS-1:0] req_row  [NUM_REQS];
  logic [BBW-1:0]      wb_bank;

  logic [NUM_BANKS-1:0] grant_vld;
  logic [RQB-1:0]       grant_idx [NUM_BANKS];
  logic [RQB-1:0]       rr_ptr_q  [NUM_BANKS];
  logic [RQB-1:0]       rr_ptr_d  [NUM_BANKS];
  logic [NUM_REQS-1:0]  fire;

  logic [NUM_REQS-1:0]           pv_q [READ_LATENCY];
  logic [NUM_REQS-1:0]           pv_d [READ_LATENCY];
  logic [NUM_REQS*BBW-1:0]       pb_q [READ_LATENCY];
  logic [NUM_REQS*BBW-1:0]       pb_d [READ_LATENCY];
  logic [NUM_REQS*TAG_WIDTH-1:0] pt_q [READ_LATENCY];
  logic [NUM_REQS*TAG_WIDTH-1:0] pt_d [READ_LATENCY];

  genvar gi;

  // Low index bits pick the bank, the rest form the row; a single bank uses the full index as row.
  generate
    for (gi = 0; gi < NUM_REQS; gi++) begin : g_map
      logic [REG_IDX_BITS-1:0] reg_i;
      assign reg_i        = req_reg[gi*REG_IDX_BITS +: REG_IDX_BITS];
      assign req_bank[gi] = (BB > 0) ? reg_i[BBW-1:0] : '0;
      assign req_row[gi]  = ROW_BITS'(reg_i >> BB);
    end
  endgenerate

  assign wb_bank = (BB > 0) ? wb_reg[BBW-1:0] : '0;

  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = '0;
    req_ready = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      grant_idx[b] = '0;
      rr_ptr_d[b]  = rr_ptr_q[b];
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (!reset && !(wb_valid && (wb_bank == BBW'(b)))) begin
        for (int k = 0; k < NUM_REQS; k++) begin
          idx = (int'(rr_ptr_q[b]) + k) % NUM_REQS;
          if (!grant_vld[b] && req_valid[idx] && (req_bank[idx] == BBW'(b))) begin
            grant_vld[b] = 1'b1;
            grant_idx[b] = RQB'(idx);
          end
        end
      end
      if (grant_vld[b]) begin
        req_ready[grant_idx[b]] = 1'b1;
        rr_ptr_d[b] = (grant_idx[b] == RQB'(NUM_REQS - 1)) ? '0 : grant_idx[b] + RQB'(1);
      end
    end
  end

  always_comb begin
    bank_rd_addr = '0;
    bank_rd_req  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (grant_vld[b]) begin
        bank_rd_addr[b*ROW_BITS +: ROW_BITS] = req_row[grant_idx[b]];
        bank_rd_req[b*RQB +: RQB]            = grant_idx[b];
      end
    end
  end

  assign bank_rd_en = grant_vld;
  assign fire       = req_valid & req_ready;

  // Response shift register; bank/tag are zeroed on idle slots so outputs stay clean.
  always_comb begin
    for (int s = 0; s < READ_LATENCY; s++) begin
      pv_d[s] = '0;
      pb_d[s] = '0;
      pt_d[s] = '0;
    end
    pv_d[0] = fire;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (fire[i]) begin
        pb_d[0][i*BBW +: BBW]             = req_bank[i];
        pt_d[0][i*TAG_WIDTH +: TAG_WIDTH] = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
    for (int s = 1; s < READ_LATENCY; s++) begin
      pv_d[s] = pv_q[s-1];
      pb_d[s] = pb_q[s-1];
      pt_d[s] = pt_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANKS; b++) rr_ptr_q[b] <= '0;
      for (int s = 0; s < READ_LATENCY; s++) begin
        pv_q[s] <= '0;
        pb_q[s] <= '0;
        pt_q[s] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      pv_q     <= pv_d;
      pb_q     <= pb_d;
      pt_q     <= pt_d;
    end
  end

  // A read still sitting at the pipe output while reset is high is discarded, not reported.
  assign rsp_valid = pv_q[READ_LATENCY-1] & {NUM_REQS{~reset}};
  assign rsp_bank  = pb_q[READ_LATENCY-1];
  assign rsp_tag   = pt_q[READ_LATENCY-1];

`ifdef GPR_ARB_PERF_EN
  logic [PERF_CTR_BITS-1:0] perf_q;
  logic [PERF_CTR_BITS-1:0] perf_d;

  always_comb begin
    perf_d = perf_q;
    if (|(req_valid & ~req_ready) && (perf_q != '1)) perf_d = perf_q + PERF_CTR_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_stalls = perf_q;
`endif

  // A pending (valid, not yet granted) request must keep its register index and tag.
  generate
    for (gi = 0; gi < NUM_REQS; gi++) begin : g_hold_chk
      assert property (@(posedge clk) disable iff (reset)
        (req_valid[gi] && $past(req_valid[gi] && !req_ready[gi] && !reset)) |->
          ((req_reg[gi*REG_IDX_BITS +: REG_IDX_BITS] == $past(req_reg[gi*REG_IDX_BITS +: REG_IDX_BITS])) &&
           (req_tag[gi*TAG_WIDTH +: TAG_WIDTH] == $past(req_tag[gi*TAG_WIDTH +: TAG_WIDTH]))));
    end
  endgenerate

endmodule

// File: tb/tb_vx_gpr_bank_arb.sv
// Directed bench for vx_gpr_bank_arb (default parameters: 4 requesters, 4 banks, 8-bit index, 2-bit tag).
module tb_vx_gpr_bank_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_reg;
  logic [7:0]  req_tag;
  logic [3:0]  req_ready;
  logic        wb_valid;
  logic [7:0]  wb_reg;
  logic [3:0]  bank_rd_en;
  logic [23:0] bank_rd_addr;
  logic [7:0]  bank_rd_req;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_bank;
  logic [7:0]  rsp_tag;
`ifdef GPR_ARB_PERF_EN
  logic [15:0] perf_stalls;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  vx_gpr_bank_arb dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_reg      (req_reg),
    .req_tag      (req_tag),
    .req_ready    (req_ready),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .bank_rd_en   (bank_rd_en),
    .bank_rd_addr (bank_rd_addr),
    .bank_rd_req  (bank_rd_req),
    .rsp_valid    (rsp_valid),
    .rsp_bank     (rsp_bank),
    .rsp_tag      (rsp_tag)
`ifdef GPR_ARB_PERF_EN
    ,
    .perf_stalls  (perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] r, input logic [1:0] t);
    req_valid[i]      = v;
    req_reg[i*8 +: 8] = r;
    req_tag[i*2 +: 2] = t;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_reg = '0; req_tag = '0; wb_valid = 1'b0; wb_reg = '0;
    tick(); tick();

    // Reset gating, then test 1: two different banks granted in parallel
    set_req(0, 1'b1, 8'h05, 2'd1);
    set_req(1, 1'b1, 8'h0A, 2'd2);
    #2;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_rd_en", 32'(bank_rd_en), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    tick(); reset = 1'b0;
    #2;
    check("t1_ready", 32'(req_ready), 32'h3);
    check("t1_rd_en", 32'(bank_rd_en), 32'h6);
    check("t1_rd_addr", 32'(bank_rd_addr), 32'h2040);
    check("t1_rd_req", 32'(bank_rd_req), 32'h10);
    check("t1_rsp_idle", 32'(rsp_valid), 32'h0);
    tick(); req_valid = '0;
    #2;
    check("t1_rsp_valid", 32'(rsp_valid), 32'h3);
    check("t1_rsp_bank", 32'(rsp_bank), 32'h09);
    check("t1_rsp_tag", 32'(rsp_tag), 32'h09);
    check("t1_idle_rd_en", 32'(bank_rd_en), 32'h0);
    tick();
    #2;
    check("t1_rsp_once", 32'(rsp_valid), 32'h0);

    // Test 2: four requesters on bank 3, strict rotation 0,1,2,3
    tick();
    set_req(0, 1'b1, 8'h03, 2'd0);
    set_req(1, 1'b1, 8'h07, 2'd1);
    set_req(2, 1'b1, 8'h0B, 2'd2);
    set_req(3, 1'b1, 8'h0F, 2'd3);
    for (int c = 0; c < 4; c++) begin
      #2;
      check($sformatf("t2_ready_c%0d", c), 32'(req_ready), 32'(4'b0001 << c));
      check($sformatf("t2_addr_c%0d", c), 32'(bank_rd_addr[18 +: 6]), 32'(c));
      check($sformatf("t2_req_c%0d", c), 32'(bank_rd_req[6 +: 2]), 32'(c));
      if (c > 0) begin
        check($sformatf("t2_rsp_valid_c%0d", c), 32'(rsp_valid), 32'(4'b0001 << (c - 1)));
        check($sformatf("t2_rsp_tag_c%0d", c), 32'(rsp_tag[(c-1)*2 +: 2]), 32'(c - 1));
      end
      tick();
      req_valid[c] = 1'b0;
    end
    #2;
    check("t2_rsp_valid_last", 32'(rsp_valid), 32'h8);
    check("t2_rsp_tag_last", 32'(rsp_tag[6 +: 2]), 32'd3);
    check("t2_rsp_bank_last", 32'(rsp_bank[6 +: 2]), 32'd3);

    // Test 3: writeback blocks bank 3 for one cycle; bank 1 unaffected
    tick();
    wb_valid = 1'b1; wb_reg = 8'h07;
    set_req(2, 1'b1, 8'h13, 2'd2);
    set_req(1, 1'b1, 8'h01, 2'd0);
    #2;
    check("t3_wb_ready", 32'(req_ready), 32'h2);
    check("t3_wb_rd_en", 32'(bank_rd_en), 32'h2);
    tick();
    wb_valid = 1'b0;
    req_valid[1] = 1'b0;
    #2;
    check("t3_ready", 32'(req_ready), 32'h4);
    check("t3_rd_en", 32'(bank_rd_en), 32'h8);
    check("t3_addr", 32'(bank_rd_addr[18 +: 6]), 32'd4);
    check("t3_req", 32'(bank_rd_req[6 +: 2]), 32'd2);
    check("t3_rsp_bank1", 32'(rsp_valid), 32'h2);
    tick();
    req_valid[2] = 1'b0;
    set_req(0, 1'b1, 8'h03, 2'd0);
    set_req(3, 1'b1, 8'h0F, 2'd3);
    #2;
    check("t3_ptr_next", 32'(req_ready), 32'h8);
    check("t3_rsp_valid", 32'(rsp_valid), 32'h4);
    check("t3_rsp_tag", 32'(rsp_tag[4 +: 2]), 32'd2);
    tick();
    req_valid[3] = 1'b0;
    #2;
    check("t3_ptr_wrap", 32'(req_ready), 32'h1);

    // Test 4: pointer at 2 on bank 0 wraps to req0
    tick();
    req_valid = '0;
    set_req(1, 1'b1, 8'h04, 2'd1);
    #2;
    check("t4_first_ready", 32'(req_ready), 32'h2);
    check("t4_first_addr", 32'(bank_rd_addr[0 +: 6]), 32'd1);
    check("t4_first_req", 32'(bank_rd_req[0 +: 2]), 32'd1);
    tick();
    set_req(0, 1'b1, 8'h00, 2'd0);
    set_req(1, 1'b1, 8'h08, 2'd1);
    #2;
    check("t4_wrap_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid[0] = 1'b0;
    #2;
    check("t4_second_ready", 32'(req_ready), 32'h2);
    check("t4_second_addr", 32'(bank_rd_addr[0 +: 6]), 32'd2);
    check("t4_rsp_valid", 32'(rsp_valid), 32'h1);

    // Test 5: reset one cycle after a fire discards it and clears pointers
    tick();
    req_valid = '0;
    set_req(2, 1'b1, 8'h06, 2'd3);
    #2;
    check("t5_fire", 32'(req_ready), 32'h4);
    tick();
    reset = 1'b1;
    req_valid = '0;
    set_req(0, 1'b1, 8'h05, 2'd1);
    #2;
    check("t5_rst_rsp", 32'(rsp_valid), 32'h0);
    check("t5_rst_ready", 32'(req_ready), 32'h0);
    check("t5_rst_rd_en", 32'(bank_rd_en), 32'h0);
    tick();
    reset = 1'b0;
    set_req(0, 1'b1, 8'h03, 2'd0);
    set_req(1, 1'b1, 8'h00, 2'd1);
    set_req(2, 1'b1, 8'h04, 2'd2);
    set_req(3, 1'b1, 8'h0F, 2'd3);
    #2;
    check("t5_post_rsp", 32'(rsp_valid), 32'h0);
    check("t5_ptr_reset", 32'(req_ready), 32'h3);
    check("t5_rd_en", 32'(bank_rd_en), 32'h9);
    tick();
    req_valid = '0;
    #2;
    check("t5_new_rsp", 32'(rsp_valid), 32'h3);

`ifdef GPR_ARB_PERF_EN
    // Test 6: three requesters on bank 1, each leaves after its grant
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 1'b1, 8'h01, 2'd0);
    set_req(1, 1'b1, 8'h05, 2'd1);
    set_req(2, 1'b1, 8'h09, 2'd2);
    #2;
    check("t6_perf_reset", 32'(perf_stalls), 32'd0);
    check("t6_ready_c0", 32'(req_ready), 32'h1);
    tick();
    req_valid[0] = 1'b0;
    #2;
    check("t6_ready_c1", 32'(req_ready), 32'h2);
    tick();
    req_valid[1] = 1'b0;
    #2;
    check("t6_ready_c2", 32'(req_ready), 32'h4);
    tick();
    req_valid[2] = 1'b0;
    #2;
    check("t6_perf", 32'(perf_stalls), 32'd2);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
